// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder in front of a
// word-wide SRAM. The request is latched on accept and the SRAM is accessed
// in one ACCESS cycle. The response is then held in RESP until it is consumed.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word accesses
// fault instead of being force-aligned).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready only when idle)
//   req_addr, req_we, req_size request byte address, store flag, size (0/1/2)
//   req_unsigned, req_wdata    load zero-extend flag, right-aligned store data
//   rsp_valid / rsp_ready      response handshake
//   rsp_rdata, rsp_err         extended load data (0 on store/error), fault
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      offset, word_idx;
    logic [IDX_W-1:0] idx;
    logic             in_range, misalign, access_err, wr_en;
    logic [1:0]       lane;
    logic [31:0]      rd_word, shifted, load_data, wr_pat, wr_word;
    logic [3:0]       be;

    // Address decode, lane selection and fault detection on the latched request
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        word_idx = offset >> 2;
        in_range = (addr_q >= BASE_ADDR) && (word_idx < 32'(DEPTH_WORDS));
        idx      = word_idx[IDX_W-1:0];
        // Half and word lanes are always taken aligned; trap mode faults on the low bits
        case (size_q)
            2'd0:    lane = addr_q[1:0];
            2'd1:    lane = {addr_q[1], 1'b0};
            default: lane = 2'd0;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = ((size_q == 2'd1) && addr_q[0]) ||
                   ((size_q == 2'd2) && (addr_q[1:0] != 2'd0));
`else
        misalign = 1'b0;
`endif
        access_err = !in_range || (size_q == 2'd3) || misalign;
    end

    // Load extraction and store merge against the current SRAM word
    always_comb begin
        rd_word = mem[idx];
        shifted = rd_word >> {lane, 3'b000};
        case (size_q)
            2'd0:    load_data = uns_q ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = uns_q ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = rd_word;
        endcase
        case (size_q)
            2'd0:    begin be = 4'b0001 << lane; wr_pat = {4{wdata_q[7:0]}};  end
            2'd1:    begin be = 4'b0011 << lane; wr_pat = {2{wdata_q[15:0]}}; end
            default: begin be = 4'b1111;         wr_pat = wdata_q;            end
        endcase
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = be[i] ? wr_pat[8*i +: 8] : rd_word[8*i +: 8];
        end
        // Reset during ACCESS kills the write
        wr_en = !reset && (state_q == ACCESS) && we_q && !access_err;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        addr_d      = addr_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = access_err;
                rsp_rdata_d = (access_err || we_q) ? 32'd0 : load_data;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Ready follows the state so it is high in every IDLE cycle
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
        end
    end

    // SRAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_word;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic checked
// against a byte-addressed reference memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int n_total = 0;
    int n_bad   = 0;

    bit [7:0] ref_b [int unsigned];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: little-endian byte memory, arithmetic sign extension
    task automatic model(input logic [31:0] a_in, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd);
        longint      off, v;
        int unsigned n, a;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a   = a_in;
        off = longint'(a_in) - longint'(BASE);
        err = (sz == 2'd3) || (off < 0) || (off >= 4 * longint'(DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (a % n != 0) err = 1'b1;
`else
        a = a - (a % n);
`endif
        rd = 32'd0;
        if (err) return;
        if (we) begin
            for (int k = 0; k < int'(n); k++) ref_b[a + k] = 8'((wd >> (8 * k)) & 32'hFF);
        end else begin
            v = 0;
            for (int k = 0; k < int'(n); k++) v += longint'(ref_b[a + k]) << (8 * k);
            if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
            rd = 32'(v);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd, input int hold,
                          output logic [31:0] got);
        logic        e_err;
        logic [31:0] e_rd;
        int          w;
        model(a, we, sz, uns, wd, e_err, e_rd);
        req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble inputs: only the latched copy may matter
        req_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom);
        req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
        chk("access_valid", 32'(rsp_valid), 32'd0);
        chk("access_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        got = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, e_rd);
            chk("hold_err", 32'(rsp_err), 32'(e_err));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        chk("consume_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got, a;
        logic [1:0]  sz;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Give every word of a 16-word window a known value
        for (int i = 0; i < 16; i++) do_req(BASE + 32'(4 * i), 1'b1, 2'd2, 1'b0, $urandom, 0, got);

        do_req(32'h8000_0010, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, got);
        do_req(32'h8000_0010, 1'b0, 2'd2, 1'b0, 32'h0, 0, got);
        chk("dir_word", got, 32'hDEAD_BEEF);
        do_req(32'h8000_0013, 1'b1, 2'd0, 1'b0, 32'h0000_005A, 0, got);
        do_req(32'h8000_0012, 1'b0, 2'd0, 1'b0, 32'h0, 0, got);
        chk("dir_byte_s", got, 32'hFFFF_FFAD);
        do_req(32'h8000_0012, 1'b0, 2'd1, 1'b1, 32'h0, 5, got);
        chk("dir_half_u", got, 32'h0000_5AAD);

        do_req(32'h7FFF_FFFC, 1'b0, 2'd2, 1'b0, 32'h0, 0, got);
        do_req(BASE + 32'(4 * DEPTH), 1'b0, 2'd2, 1'b0, 32'h0, 0, got);
        do_req(32'h8000_0010, 1'b1, 2'd3, 1'b0, 32'h1234_5678, 0, got);
        do_req(32'h8000_0010, 1'b0, 2'd2, 1'b0, 32'h0, 0, got);
        chk("dir_unchanged", got, 32'h5AAD_BEEF);

        do_req(32'h8000_0022, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 0, got);
        do_req(32'h8000_0020, 1'b0, 2'd2, 1'b0, 32'h0, 1, got);

        // Reset during ACCESS of a store must drop the write and the response
        do_req(32'h8000_0030, 1'b1, 2'd2, 1'b0, 32'h2222_2222, 0, got);
        req_valid = 1'b1; req_addr = 32'h8000_0030; req_we = 1'b1;
        req_size = 2'd2; req_wdata = 32'h1111_1111;
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_access", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_idle", 32'(req_ready), 32'd1);
        do_req(32'h8000_0030, 1'b0, 2'd2, 1'b0, 32'h0, 0, got);
        chk("abort_mem", got, 32'h2222_2222);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, 63));
            else case ($urandom_range(0, 3))
                0: a = 32'h7FFF_FFFC;
                1: a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
                2: a = 32'h0000_0000;
                default: a = 32'hFFFF_FFFC;
            endcase
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(a, 1'($urandom), sz, 1'($urandom), $urandom, $urandom_range(0, 3), got);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
